// File: rtl/fifo_burst_reader.sv
// Read-side burst master for sync_fifo: on start, drains burst_len words from
// the FIFO read port and presents them as a valid/ready stream with m_last on
// the final word. A 2-entry buffer absorbs the FIFO read latency so data is
// never dropped under backpressure and the FIFO is never read while empty.
// Optional idle timeout abort: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned RDATA_MODE = 1,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [LEN_WIDTH-1:0]  rd_count
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    // Show-ahead FIFOs return data in the same cycle as the read strobe.
    localparam bit SHOW_AHEAD = (RDATA_MODE == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                  l0_q, l0_d, l1_q, l1_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;
    logic                  done_q, done_d;

    logic                  pop_c;
    logic                  push_c;
    logic                  push_last_c;
    logic [1:0]            fill_c;
    logic                  rd_en_c;
    logic                  abort_c;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
`endif

    // Read issue: never while empty, never past 2 words buffered or in flight.
    always_comb begin
        pop_c       = (occ_q != 2'd0) && m_ready;
        fill_c      = occ_q + 2'(infl_q);
        rd_en_c     = (state_q == S_RUN) && !fifo_empty && (rem_q != '0) &&
                      ((fill_c < 2'd2) || ((fill_c == 2'd2) && pop_c));
        push_c      = SHOW_AHEAD ? rd_en_c : infl_q;
        push_last_c = SHOW_AHEAD ? (rem_q == LEN_WIDTH'(1)) : infl_last_q;
        infl_d      = SHOW_AHEAD ? 1'b0 : rd_en_c;
        infl_last_d = SHOW_AHEAD ? 1'b0 : (rd_en_c && (rem_q == LEN_WIDTH'(1)));
    end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Idle watchdog: counts empty-FIFO cycles in RUN, cleared by any read.
    always_comb begin
        to_d    = to_q;
        abort_c = (state_q == S_RUN) && fifo_empty && (to_q == TO_W'(TIMEOUT - 1));
        if ((state_q == S_IDLE) && start && (burst_len != '0)) begin
            to_d = '0;
        end else if (rd_en_c) begin
            to_d = '0;
        end else if ((state_q == S_RUN) && fifo_empty) begin
            to_d = to_q + TO_W'(1);
        end
        err_d = err_q | abort_c;
    end
`else
    assign abort_c = 1'b0;
`endif

    // Burst sequencing: IDLE -> RUN while reads remain -> DRAIN until emptied.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (pop_c) begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start && (burst_len != '0)) begin
                    rem_d   = burst_len;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en_c) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
                if (abort_c) begin
                    rem_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!infl_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_c))) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry in-order buffer; entry 0 is the stream head.
    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        occ_d = occ_q;
        case ({push_c, pop_c})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    d0_d = fifo_rd_data;
                    l0_d = push_last_c;
                end else begin
                    d1_d = fifo_rd_data;
                    l1_d = push_last_c;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                d0_d  = d1_q;
                l0_d  = l1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    d0_d = fifo_rd_data;
                    l0_d = push_last_c;
                end else begin
                    d0_d = d1_q;
                    l0_d = l1_q;
                    d1_d = fifo_rd_data;
                    l1_d = push_last_c;
                end
            end
            default: ;
        endcase
        // An aborted burst ends on the youngest buffered word.
        if (abort_c) begin
            if (occ_d == 2'd2) begin
                l1_d = 1'b1;
            end else if (occ_d == 2'd1) begin
                l0_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            cnt_q       <= '0;
            occ_q       <= 2'd0;
            d0_q        <= '0;
            d1_q        <= '0;
            l0_q        <= 1'b0;
            l1_q        <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            l0_q        <= l0_d;
            l1_q        <= l1_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`endif

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign fifo_rd_en = rd_en_c;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = d0_q;
    assign m_last     = (occ_q != 2'd0) && l0_q;
    assign rd_count   = cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (registered-read FIFO model).
module tb_fifo_burst_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [LW-1:0] rd_count;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    logic          timeout_err;
`endif

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .RDATA_MODE(1),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .rd_count    (rd_count)
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model with one-cycle registered read data; not affected by rst.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Stream monitor: records accepted words and protocol violations.
    int            cyc = 0;
    logic [DW-1:0] out_d [0:63];
    logic          out_l [0:63];
    int            out_c [0:63];
    int            out_n = 0;
    int            done_n = 0;
    int            done_c = 0;
    int            outst = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    logic          stall_err = 1'b0;
    logic          ovf_err = 1'b0;
    logic          unf_err = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_empty) unf_err <= 1'b1;
        if (rst) begin
            outst   <= 0;
            stall_q <= 1'b0;
        end else begin
            if (m_valid && m_ready && out_n < 64) begin
                out_d[out_n] <= m_data;
                out_l[out_n] <= m_last;
                out_c[out_n] <= cyc;
                out_n        <= out_n + 1;
            end
            if (done) begin
                done_n <= done_n + 1;
                done_c <= cyc;
            end
            if (stall_q && (!m_valid || m_data !== held_d || m_last !== held_l)) stall_err <= 1'b1;
            stall_q <= m_valid && !m_ready;
            held_d  <= m_data;
            held_l  <= m_last;
            if (fifo_rd_en && outst >= 2 && !(m_valid && m_ready)) ovf_err <= 1'b1;
            outst <= outst + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr++;
    endtask

    task automatic start_burst(input logic [LW-1:0] len);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
        burst_len = '0;
    endtask

    task automatic wait_done(input int dn, input int budget, input string tag);
        int k;
        k = 0;
        while (done_n == dn && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(done_n - dn), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_rden"},  32'(fifo_rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(m_valid),    32'd0);
        chk({tag, "_data"},  32'(m_data),     32'd0);
        chk({tag, "_last"},  32'(m_last),     32'd0);
        chk({tag, "_count"}, 32'(rd_count),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int dn;
        int st;
        rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1;
        tick(); tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // Streaming burst of 4 with m_ready high.
        push(8'hA5); push(8'hA6); push(8'hA7); push(8'hA8);
        tick();
        base = out_n; dn = done_n; st = cyc;
        start_burst(8'd4);
        wait_done(dn, 40, "t1_done");
        chk("t1_n", 32'(out_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", 32'(out_d[base+i]), 32'(8'hA5 + i));
            chk("t1_last", 32'(out_l[base+i]), 32'(i == 3));
        end
        chk("t1_latency", 32'(out_c[base] - st), 32'd3);
        chk("t1_b2b", 32'(out_c[base+3] - out_c[base]), 32'd3);
        chk("t1_done_at", 32'(done_c - out_c[base+3]), 32'd1);
        chk("t1_count", 32'(rd_count), 32'd4);
        chk("t1_busy", 32'(busy), 32'd0);

        // Alternating backpressure.
        push(8'h30); push(8'h31); push(8'h32); push(8'h33);
        tick();
        base = out_n; dn = done_n;
        start_burst(8'd4);
        for (int i = 0; i < 60 && done_n == dn; i++) begin
            m_ready = ~m_ready;
            tick();
        end
        m_ready = 1'b1;
        chk("t2_done", 32'(done_n - dn), 32'd1);
        chk("t2_n", 32'(out_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", 32'(out_d[base+i]), 32'(8'h30 + i));
            chk("t2_last", 32'(out_l[base+i]), 32'(i == 3));
        end
        chk("t2_stable", 32'(stall_err), 32'd0);
        chk("t2_overfill", 32'(ovf_err), 32'd0);
        chk("t2_count", 32'(rd_count), 32'd4);

        // Start on an empty FIFO, words trickle in.
        base = out_n; dn = done_n;
        start_burst(8'd3);
        tick(); tick(); tick();
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_valid", 32'(m_valid), 32'd0);
        chk("t3_rden", 32'(fifo_rd_en), 32'd0);
        push(8'h11); repeat (5) tick();
        push(8'h22); repeat (5) tick();
        push(8'h33);
        wait_done(dn, 40, "t3_done");
        chk("t3_n", 32'(out_n - base), 32'd3);
        chk("t3_d0", 32'(out_d[base]),   32'h11);
        chk("t3_d1", 32'(out_d[base+1]), 32'h22);
        chk("t3_d2", 32'(out_d[base+2]), 32'h33);
        chk("t3_last", 32'(out_l[base+2]), 32'd1);
        chk("t3_underflow", 32'(unf_err), 32'd0);
        chk("t3_count", 32'(rd_count), 32'd3);

        // Zero-length start is a no-op.
        dn = done_n;
        start_burst(8'd0);
        chk("t4_zero_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("t4_zero_done", 32'(done_n - dn), 32'd0);
        chk("t4_zero_count", 32'(rd_count), 32'd3);

        // Start during RUN is ignored.
        push(8'h40); push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        tick();
        base = out_n; dn = done_n;
        start_burst(8'd3);
        start = 1'b1; burst_len = 8'd7;
        tick();
        start = 1'b0; burst_len = '0;
        wait_done(dn, 40, "t4_done");
        repeat (10) tick();
        chk("t4_one_done", 32'(done_n - dn), 32'd1);
        chk("t4_n", 32'(out_n - base), 32'd3);
        chk("t4_d2", 32'(out_d[base+2]), 32'h42);
        chk("t4_count", 32'(rd_count), 32'd3);
        chk("t4_left", 32'(wr_ptr - rd_ptr), 32'd2);
        base = out_n; dn = done_n;
        start_burst(8'd2);
        wait_done(dn, 40, "t4_drain_done");
        chk("t4_d3", 32'(out_d[base]), 32'h43);
        chk("t4_d4", 32'(out_d[base+1]), 32'h44);
        chk("t4_last", 32'(out_l[base+1]), 32'd1);

        // Reset after two of six words.
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        tick();
        base = out_n;
        start_burst(8'd6);
        repeat (4) tick();
        chk("t5_before", 32'(out_n - base), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("t5_rst");
        chk("t5_left", 32'(wr_ptr - rd_ptr), 32'd4);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t5_after", 32'(out_n - base), 32'd2);
        base = out_n; dn = done_n;
        start_burst(8'd4);
        wait_done(dn, 40, "t5_done");
        chk("t5_n", 32'(out_n - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_data", 32'(out_d[base+i]), 32'(8'h54 + i));
            chk("t5_last", 32'(out_l[base+i]), 32'(i == 3));
        end
        chk("t5_count", 32'(rd_count), 32'd4);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // Timeout abort with two words held under backpressure.
        push(8'h61); push(8'h62);
        tick();
        base = out_n; dn = done_n;
        m_ready = 1'b0;
        start_burst(8'd5);
        repeat (17) tick();
        chk("t6_err_pre", 32'(timeout_err), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        tick();
        chk("t6_err", 32'(timeout_err), 32'd1);
        m_ready = 1'b1;
        wait_done(dn, 40, "t6_done");
        chk("t6_n", 32'(out_n - base), 32'd2);
        chk("t6_d0", 32'(out_d[base]), 32'h61);
        chk("t6_l0", 32'(out_l[base]), 32'd0);
        chk("t6_d1", 32'(out_d[base+1]), 32'h62);
        chk("t6_l1", 32'(out_l[base+1]), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_sticky", 32'(timeout_err), 32'd1);
        chk("t6_count", 32'(rd_count), 32'd2);
`endif

        chk("end_underflow", 32'(unf_err), 32'd0);
        chk("end_overfill", 32'(ovf_err), 32'd0);
        chk("end_stable", 32'(stall_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
